misc_ins: RTL

MISC_INS -- requirements
Module: misc_ins

---
 rtl/misc_ins_if.sv | 12 +
 rtl/misc_ins.sv | 42 ++++
 2 files changed

// File: rtl/misc_ins_if.sv
// misc_ins_if: Avalon-MM slave register bus plus the level interrupt of the misc_ins block.
interface misc_ins_if;
  logic [1:0] address;
  logic       chipselect;
  logic       read_n;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       irq;
  modport master(output address, chipselect, read_n, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, read_n, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/misc_ins.sv
// misc_ins: synchronized, debounced 8-bit status inputs with edge capture, interrupt mask and Avalon register access.
module misc_ins #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_port,
  misc_ins_if.slave  bus
);
  localparam logic [7:0] last = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] s1, s2, filt, mask, cap, acc, hit, clr;
  logic [7:0] cnt [8];
  logic wr, rd;
  // acc marks bits whose disagreement has lasted long enough to be accepted on this edge
  always_comb begin
    wr = bus.chipselect && !bus.write_n;
    rd = bus.chipselect && !bus.read_n;
    for (int b = 0; b < 8; b++) acc[b] = (s2[b] != filt[b]) && (cnt[b] == last);
    hit = EDGE_MODE == 0 ? acc & s2 : EDGE_MODE == 1 ? acc & ~s2 : acc;
    clr = (wr && bus.address == 2'd3) ? bus.writedata : 8'h00;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      filt <= '0;
      mask <= '0;
      cap <= '0;
      bus.readdata <= '0;
      for (int b = 0; b < 8; b++) cnt[b] <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      filt <= filt ^ acc;
      cap <= (cap & ~clr) | hit;
      if (wr && bus.address == 2'd2) mask <= bus.writedata;
      if (rd) bus.readdata <= bus.address == 2'd0 ? filt : bus.address == 2'd1 ? s2 : bus.address == 2'd2 ? mask : cap;
      for (int b = 0; b < 8; b++) cnt[b] <= (s2[b] == filt[b] || acc[b]) ? 8'd0 : cnt[b] + 8'd1;
    end
  assign bus.irq = |(cap & mask);
endmodule
